mux4_scan_ctrl: RTL and testbench
=================================

# mux4_scan_ctrl

Sequencer that sits directly upstream of the 4:1 gate-level mux: it drives the mux select lines through channels 0→3 and samples the mux output once per channel. It assembles the four samples into a 4-bit word and hands the word downstream with a valid/ready handshake. A bench or top level ties `sel` to the mux `S` input and the mux `OUT` to `mux_out`. With `mux_out = I[sel]`, the block reconstructs `I`.

## Interface
- `SETTLE_CYC`, default 1: cycles each select value is held before sampling. Legal range 1..255.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one scan; accepted only in IDLE.
- `mux_out` in 1: output of the 4:1 mux.
- `word_ready` in 1: downstream accepts `word`.
- `sel` out 2: mux select, bit 1 = S[1], bit 0 = S[0].
- `word` out 4: assembled samples, `word[k]` = `mux_out` sampled while `sel==k`.
- `word_valid` out 1: `word` is complete and stable.
- `busy` out 1: high from scan acceptance until handshake completes.

## Operation
- Reset values: `sel`=0, `word`=0, `word_valid`=0, `busy`=0, state IDLE, settle counter=0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE, `start`=1:
  - `sel`←0, counter←`SETTLE_CYC`-1, `busy`←1, go to SETTLE.
  - `word` is not cleared; bits are overwritten as they are sampled.
- SETTLE, counter≠0: decrement, hold `sel`.
- SETTLE, counter==0: `word[sel]`←`mux_out`. Then:
  - If `sel`≠3: `sel`←`sel`+1, counter←`SETTLE_CYC`-1, stay in SETTLE.
  - If `sel`==3: `word_valid`←1, go to DONE. `sel` stays at 3.
- DONE: hold `word`, `sel` and `word_valid` until `word_ready`=1 at an edge. Then `word_valid`←0, `busy`←0, `sel`←0, go to IDLE.
- `start` outside IDLE is ignored. This includes DONE, even in the same cycle as `word_ready`.
- `word_ready` outside DONE has no effect.
- `rst` has priority over everything. Mid-scan reset returns all outputs to reset values on that edge, and the partial word is discarded.
- Counter is 8 bits. `sel` increments only 0→3 and never wraps inside a scan.

## Timing
- `start` accepted at edge E0 → `busy`=1 and `sel`=0 after E0.
- Sample of channel k taken at edge E0 + (k+1)·`SETTLE_CYC`.
- `sel` changes to k+1 on the same edge as the channel-k sample.
- `word_valid` rises at E0 + 4·`SETTLE_CYC`. With default 1, `word_valid` rises 4 cycles after start acceptance.
- Handshake completes on the first edge with `word_valid`=1 and `word_ready`=1. `word_valid` falls after that edge.
- Minimum start-to-start period: 4·`SETTLE_CYC` + 2 cycles (one DONE cycle, one IDLE cycle).
- `mux_out` must be stable at every sampling edge; it is not synchronised internally.

## Configuration
- Macro `MUX4_SCAN_CONT_EN`.
- Defined: handshake completion in DONE restarts the scan instead of going to IDLE:
  - `sel`←0, counter reloaded, `busy` stays 1, go to SETTLE.
  - `start` is then only needed for the first scan.
  - Reset still returns to IDLE.
- Undefined: single-shot behaviour exactly as in Operation.

## Structure
- Shared package `mux4_scan_pkg` holds:
  - state enum (IDLE, SETTLE, DONE)
  - `NUM_CH`=4
  - `SEL_W`=2
  - `CNT_W`=8
  - `LAST_SEL`=2'b11
- One sub-module, `mux4_scan_settle_cnt`: loadable down-counter with a `load`, a `load_val` and a `zero` flag. The FSM instantiates it once.
- Top-level FSM, `sel` register and word register live in `mux4_scan_ctrl`.

## Test plan
- Bench models the mux as `mux_out = I[sel]`, `I`=4'b1010, `SETTLE_CYC`=1. Pulse `start`, hold `word_ready`=1. Required:
  - `sel` steps 0,1,2,3 on consecutive cycles.
  - `word_valid` rises 4 cycles after start, with `word`=4'b1010.
  - `word_valid` drops the next cycle.
- `SETTLE_CYC`=3, `I`=4'b0110. Required:
  - each `sel` value held 3 cycles.
  - `word_valid` at start+12 with `word`=4'b0110.
- Backpressure: `word_ready`=0 for 5 cycles after `word_valid`. Required:
  - `word`, `sel`=3 and `word_valid`=1 stay frozen.
  - `start` pulses during this time are ignored.
  - handshake completes on the edge after `word_ready` rises.
- Mid-scan reset: `rst`=1 while `sel`=2. Required:
  - next cycle `sel`=0, `word`=0, `busy`=0, `word_valid`=0.
  - a fresh start then yields the correct word.
- `MUX4_SCAN_CONT_EN` defined, `I` changed from 4'b1010 to 4'b0101 between scans. Required:
  - back-to-back words 4'b1010 then 4'b0101 without a second `start`.
  - `busy` stays 1 throughout.
- `I`=4'b1111 then 4'b0000 across two single-shot scans. Required: stale bits never leak, and the second `word`=4'b0000.

Source files
------------

// File: rtl/mux4_scan_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: FSM state encoding,
// channel count and register widths used by the controller and its counter.
package mux4_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [SEL_W-1:0] LAST_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

endpackage : mux4_scan_pkg

// File: rtl/mux4_scan_settle_cnt.sv
// Loadable settle down-counter. Loading wins over decrementing; the counter
// saturates at zero so a stray decrement can never wrap it to 255.
module mux4_scan_settle_cnt
  import mux4_scan_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, otherwise decrement while non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule : mux4_scan_settle_cnt

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select lines 0..3, holds each for
// SETTLE_CYC cycles, samples the mux output into word[sel] and presents the
// assembled word with a valid/ready handshake.
// Optional build macro MUX4_SCAN_CONT_EN: when defined, completing the
// handshake immediately starts the next scan instead of returning to idle.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mux_out_i,
  input  logic              word_ready_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [NUM_CH-1:0] word_o,
  output logic              word_valid_o,
  output logic              busy_o
);

  // Reload value is the hold time minus the sampling cycle itself.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;

  mux4_scan_settle_cnt u_settle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load_s),
    .load_val_i (RELOAD),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Scan FSM: next state, select, word bits and handshake flags.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    word_d     = word_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // word is intentionally not cleared; each bit is overwritten.
          sel_d      = {SEL_W{1'b0}};
          cnt_load_s = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!cnt_zero_s) begin
          cnt_dec_s = 1'b1;
        end else begin
          word_d[sel_q] = mux_out_i;
          if (sel_q != LAST_SEL) begin
            sel_d      = sel_q + 2'd1;
            cnt_load_s = 1'b1;
          end else begin
            // sel stays at the last channel while the word is offered.
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here.
        if (word_ready_i) begin
          valid_d = 1'b0;
          sel_d   = {SEL_W{1'b0}};
`ifdef MUX4_SCAN_CONT_EN
          cnt_load_s = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_SETTLE;
`else
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = {SEL_W{1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= {SEL_W{1'b0}};
      word_q  <= {NUM_CH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sel_o        = sel_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign busy_o       = busy_q;

endmodule : mux4_scan_ctrl

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: two instances (SETTLE_CYC 1 and 3),
// each fed by a behavioural mux model out = I[sel].
`timescale 1ns/1ps
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, ready1, mux1;
  logic [3:0] i1;
  logic [1:0] sel1;
  logic [3:0] word1;
  logic       valid1, busy1;
  logic       start3, ready3, mux3;
  logic [3:0] i3;
  logic [1:0] sel3;
  logic [3:0] word3;
  logic       valid3, busy3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mux1 = i1[sel1];
  assign mux3 = i3[sel3];

  mux4_scan_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .mux_out_i(mux1),
    .word_ready_i(ready1), .sel_o(sel1), .word_o(word1),
    .word_valid_o(valid1), .busy_o(busy1)
  );

  mux4_scan_ctrl #(.SETTLE_CYC(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .mux_out_i(mux3),
    .word_ready_i(ready3), .sel_o(sel3), .word_o(word3),
    .word_valid_o(valid3), .busy_o(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check the full output set of dut1 in one call.
  task automatic chk1(input string tag, input logic [1:0] s, input logic [3:0] w,
                      input logic v, input logic b);
    chk({tag, ".sel"},   {2'b00, sel1}, {2'b00, s});
    chk({tag, ".word"},  word1, w);
    chk({tag, ".valid"}, {3'b000, valid1}, {3'b000, v});
    chk({tag, ".busy"},  {3'b000, busy1}, {3'b000, b});
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; ready1 = 1'b1; i1 = 4'b0000;
    start3 = 1'b0; ready3 = 1'b1; i3 = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    chk1("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    tick();
    chk1("idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // SETTLE_CYC=3 instance, I=0110
    i3 = 4'b0110; start3 = 1'b1;
    tick(); start3 = 1'b0;
    chk("s3.e0.sel", {2'b00, sel3}, 4'd0);
    chk("s3.e0.busy", {3'b000, busy3}, 4'd1);
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("s3.sel", {2'b00, sel3}, (t < 12) ? 4'(t / 3) : 4'd3);
      chk("s3.valid", {3'b000, valid3}, (t == 12) ? 4'd1 : 4'd0);
    end
    chk("s3.word", word3, 4'b0110);
    tick();
    chk("s3.hs.valid", {3'b000, valid3}, 4'd0);

`ifndef MUX4_SCAN_CONT_EN
    // Basic scan, I=1010, ready held high
    i1 = 4'b1010; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk1("b.e0", 2'd0, 4'b0000, 1'b0, 1'b1);
    tick(); chk1("b.e1", 2'd1, 4'b0000, 1'b0, 1'b1);
    tick(); chk1("b.e2", 2'd2, 4'b0010, 1'b0, 1'b1);
    tick(); chk1("b.e3", 2'd3, 4'b0010, 1'b0, 1'b1);
    tick(); chk1("b.e4", 2'd3, 4'b1010, 1'b1, 1'b1);
    tick(); chk1("b.e5", 2'd0, 4'b1010, 1'b0, 1'b0);

    // Backpressure with ignored start pulses, I=1100
    ready1 = 1'b0; i1 = 4'b1100; start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick(); tick(); tick(); tick();
    chk1("bp.valid", 2'd3, 4'b1100, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      start1 = ~start1;
      i1 = 4'b0011;
      tick();
      chk1("bp.hold", 2'd3, 4'b1100, 1'b1, 1'b1);
    end
    start1 = 1'b1; ready1 = 1'b1;
    tick(); start1 = 1'b0;
    chk1("bp.hs", 2'd0, 4'b1100, 1'b0, 1'b0);
    tick();
    chk1("bp.idle", 2'd0, 4'b1100, 1'b0, 1'b0);

    // Mid-scan reset at sel=2, I=0111
    i1 = 4'b0111; start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick(); tick();
    chk1("mr.pre", 2'd2, 4'b1111, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk1("mr.rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick(); tick(); tick(); tick();
    chk1("mr.word", 2'd3, 4'b0111, 1'b1, 1'b1);
    tick();

    // Stale-bit check: 1111 then 0000
    i1 = 4'b1111; start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick(); tick(); tick(); tick();
    chk1("st.a", 2'd3, 4'b1111, 1'b1, 1'b1);
    tick();
    i1 = 4'b0000; start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick(); chk("st.b1", word1, 4'b1110);
    tick(); chk("st.b2", word1, 4'b1100);
    tick(); chk("st.b3", word1, 4'b1000);
    tick(); chk1("st.b4", 2'd3, 4'b0000, 1'b1, 1'b1);
    tick();
`else
    // Continuous mode: one start, words 1010 then 0101
    i1 = 4'b1010; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk1("c.e0", 2'd0, 4'b0000, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk("c.busy3", {3'b000, busy1}, 4'd1);
    tick(); chk1("c.w1", 2'd3, 4'b1010, 1'b1, 1'b1);
    i1 = 4'b0101;
    tick(); chk1("c.restart", 2'd0, 4'b1010, 1'b0, 1'b1);
    tick(); chk("c.busy.a", {3'b000, busy1}, 4'd1);
    tick(); chk("c.busy.b", {3'b000, busy1}, 4'd1);
    tick(); chk("c.busy.c", {3'b000, busy1}, 4'd1);
    tick(); chk1("c.w2", 2'd3, 4'b0101, 1'b1, 1'b1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk1("c.rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    tick();
    chk1("c.idle", 2'd0, 4'b0000, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mux4_scan_ctrl
